// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: widths, register zero, ALU opcodes, ID/EX payload.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 4;

  localparam logic [REG_W-1:0]  REG_ZERO = 5'd0;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic [REG_W-1:0]  rs_addr;
    logic [REG_W-1:0]  rt_addr;
    logic [REG_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_payload_t;

  // $zero is hard-wired, so it never aliases a producer.
  function automatic logic reg_match(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction
endpackage

// File: rtl/fwd_unit.sv
// Operand match/priority and stall detection for the ID/EX stage.
// ID_EX_FORWARDING_EN: forward MEM/WB results and stall only on load-use.
module fwd_unit
  import mips_pkg::*;
(
  input  logic              ex_valid,
  input  logic [REG_W-1:0]  ex_rd_addr,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_W-1:0]  id_rs_addr,
  input  logic [REG_W-1:0]  id_rt_addr,
  input  logic              id_use_imm,
  input  logic              id_mem_write,
  input  logic [REG_W-1:0]  mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [REG_W-1:0]  wb_rd_addr,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [REG_W-1:0]  held_rs_addr,
  input  logic [REG_W-1:0]  held_rt_addr,
  input  logic [DATA_W-1:0] held_rs_data,
  input  logic [DATA_W-1:0] held_rt_data,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data,
  output logic              hazard
);
`ifdef ID_EX_FORWARDING_EN
  logic mem_ok;
  logic unused_ok;
  // A load's MEM-stage value is an address, not data; only ALU results forward from MEM.
  assign mem_ok = mem_reg_write && !mem_mem_read;

  assign fwd_rs_data = (mem_ok && reg_match(held_rs_addr, mem_rd_addr))       ? mem_result :
                       (wb_reg_write && reg_match(held_rs_addr, wb_rd_addr))  ? wb_result  :
                                                                                 held_rs_data;
  assign fwd_rt_data = (mem_ok && reg_match(held_rt_addr, mem_rd_addr))       ? mem_result :
                       (wb_reg_write && reg_match(held_rt_addr, wb_rd_addr))  ? wb_result  :
                                                                                 held_rt_data;

  assign hazard = ex_valid && ex_mem_read &&
                  (reg_match(id_rs_addr, ex_rd_addr) ||
                   (!id_use_imm && reg_match(id_rt_addr, ex_rd_addr)));

  assign unused_ok = ^{ex_reg_write, id_mem_write};
`else
  logic rt_used;
  logic unused_ok;

  function automatic logic reads(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] rs,
                                 input logic [REG_W-1:0] rt, input logic rt_src);
    return reg_match(rs, dst) || (rt_src && reg_match(rt, dst));
  endfunction

  // Stores read rt as data even though their ALU operand is the immediate.
  assign rt_used = !id_use_imm || id_mem_write;

  assign fwd_rs_data = held_rs_data;
  assign fwd_rt_data = held_rt_data;

  assign hazard = (ex_valid && ex_reg_write && reads(ex_rd_addr, id_rs_addr, id_rt_addr, rt_used)) ||
                  (mem_reg_write && reads(mem_rd_addr, id_rs_addr, id_rt_addr, rt_used)) ||
                  (wb_reg_write && reads(wb_rd_addr, id_rs_addr, id_rt_addr, rt_used));

  assign unused_ok = ^{ex_mem_read, mem_mem_read, mem_result, wb_result, held_rs_addr, held_rt_addr};
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with valid/ready handshake, flush and hazard stall.
// Define ID_EX_FORWARDING_EN to enable MEM/WB operand forwarding.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic              flush,
  input  logic [REG_W-1:0]  id_rs_addr,
  input  logic [REG_W-1:0]  id_rt_addr,
  input  logic [REG_W-1:0]  id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic [REG_W-1:0]  mem_rd_addr,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [REG_W-1:0]  wb_rd_addr,
  input  logic              wb_reg_write,
  input  logic [DATA_W-1:0] wb_result,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_rd_addr,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);
  ex_payload_t       held;
  logic              hazard;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  fwd_unit u_fwd (
    .ex_valid      (ex_valid),
    .ex_rd_addr    (held.rd_addr),
    .ex_reg_write  (held.reg_write),
    .ex_mem_read   (held.mem_read),
    .id_rs_addr    (id_rs_addr),
    .id_rt_addr    (id_rt_addr),
    .id_use_imm    (id_use_imm),
    .id_mem_write  (id_mem_write),
    .mem_rd_addr   (mem_rd_addr),
    .mem_reg_write (mem_reg_write),
    .mem_mem_read  (mem_mem_read),
    .mem_result    (mem_result),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_result     (wb_result),
    .held_rs_addr  (held.rs_addr),
    .held_rt_addr  (held.rt_addr),
    .held_rs_data  (held.rs_data),
    .held_rt_data  (held.rt_data),
    .fwd_rs_data   (fwd_rs),
    .fwd_rt_data   (fwd_rt),
    .hazard        (hazard)
  );

  assign id_ready = !rst && !hazard && (!ex_valid || ex_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      held     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (id_valid && id_ready) begin
      ex_valid       <= 1'b1;
      held.rs_addr   <= id_rs_addr;
      held.rt_addr   <= id_rt_addr;
      held.rd_addr   <= id_rd_addr;
      held.rs_data   <= id_rs_data;
      held.rt_data   <= id_rt_data;
      held.imm       <= id_imm;
      held.use_imm   <= id_use_imm;
      held.alu_ctrl  <= id_alu_ctrl;
      held.reg_write <= id_reg_write;
      held.mem_read  <= id_mem_read;
      held.mem_write <= id_mem_write;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_in1        = fwd_rs;
  assign ex_in2        = held.use_imm ? held.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_ctrl       = held.alu_ctrl;
  assign ex_rd_addr    = held.rd_addr;
  assign ex_reg_write  = ex_valid && held.reg_write;
  assign ex_mem_read   = ex_valid && held.mem_read;
  assign ex_mem_write  = ex_valid && held.mem_write;
endmodule
